// File: rtl/dffce_reg.sv
// dffce_reg: WIDTH-bit D register with clock enable and asynchronous active-high clear.
// Optional macro DFFCE_PARITY_EN adds a registered even-parity output QP.
module dffce_reg #(
  parameter int   WIDTH         = 1,
  parameter       INIT          = {WIDTH{1'b0}},
  parameter logic IS_C_INVERTED = 1'b0,
  parameter       IS_D_INVERTED = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef DFFCE_PARITY_EN
  ,
  output logic             QP
`endif
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] DINV_V = WIDTH'(IS_D_INVERTED);

  generate
    if (WIDTH < 1) begin : g_chk_width
      $fatal(1, "dffce_reg: WIDTH must be at least 1");
    end
    if (|(INIT >> WIDTH)) begin : g_chk_init
      $fatal(1, "dffce_reg: INIT is wider than WIDTH");
    end
    if (|(IS_D_INVERTED >> WIDTH)) begin : g_chk_dinv
      $fatal(1, "dffce_reg: IS_D_INVERTED is wider than WIDTH");
    end
  endgenerate

  // Declaration initialiser gives the power-up value (FPGA register init).
  logic [WIDTH-1:0] q_p0 = INIT_V;
  logic [WIDTH-1:0] d_p0;

  assign d_p0 = D ^ DINV_V;

`ifdef DFFCE_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  localparam logic INIT_P = even_par(INIT_V);

  logic qp_p0 = INIT_P;

  generate
    if (IS_C_INVERTED) begin : g_neg
      always_ff @(negedge C or posedge CLR) begin
        if (CLR) begin
          q_p0  <= '0;
          qp_p0 <= 1'b0;
        end else if (CE) begin
          q_p0  <= d_p0;
          qp_p0 <= even_par(d_p0);
        end
      end
    end else begin : g_pos
      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          q_p0  <= '0;
          qp_p0 <= 1'b0;
        end else if (CE) begin
          q_p0  <= d_p0;
          qp_p0 <= even_par(d_p0);
        end
      end
    end
  endgenerate

  assign QP = qp_p0;
`else
  generate
    if (IS_C_INVERTED) begin : g_neg
      always_ff @(negedge C or posedge CLR) begin
        if (CLR)     q_p0 <= '0;
        else if (CE) q_p0 <= d_p0;
      end
    end else begin : g_pos
      always_ff @(posedge C or posedge CLR) begin
        if (CLR)     q_p0 <= '0;
        else if (CE) q_p0 <= d_p0;
      end
    end
  endgenerate
`endif

  assign Q = q_p0;

endmodule

// File: tb/tb_dffce_reg.sv
// Directed testbench for dffce_reg: clear, capture/hold, async clear, ripple divider,
// data/clock inversion, power-up value and (with DFFCE_PARITY_EN) parity output.
module tb_dffce_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single-bit register
  logic       clr1, ce1;
  logic [0:0] d1, q1;
  // 8-bit register with INIT, used for power-up and parity
  logic       clri, cei;
  logic [7:0] di, qi;
  // ripple divider chain
  logic       clr_div;
  logic [0:0] qs0, qs1, qs2;
  logic [0:0] ds0, ds1, ds2;
  // 8-bit inverted clock / inverted-D register
  logic       clr8, ce8;
  logic [7:0] d8, q8;

  assign ds0 = ~qs0;
  assign ds1 = ~qs1;
  assign ds2 = ~qs2;

`ifdef DFFCE_PARITY_EN
  logic qp1, qpi, qps0, qps1, qps2, qp8;
`endif

  dffce_reg #(.WIDTH(1)) u1 (
    .C(clk), .CLR(clr1), .CE(ce1), .D(d1), .Q(q1)
`ifdef DFFCE_PARITY_EN
    , .QP(qp1)
`endif
  );

  dffce_reg #(.WIDTH(8), .INIT(8'h38)) ui (
    .C(clk), .CLR(clri), .CE(cei), .D(di), .Q(qi)
`ifdef DFFCE_PARITY_EN
    , .QP(qpi)
`endif
  );

  dffce_reg #(.WIDTH(1)) s0 (
    .C(clk), .CLR(clr_div), .CE(1'b1), .D(ds0), .Q(qs0)
`ifdef DFFCE_PARITY_EN
    , .QP(qps0)
`endif
  );

  dffce_reg #(.WIDTH(1)) s1 (
    .C(qs0[0]), .CLR(clr_div), .CE(1'b1), .D(ds1), .Q(qs1)
`ifdef DFFCE_PARITY_EN
    , .QP(qps1)
`endif
  );

  dffce_reg #(.WIDTH(1)) s2 (
    .C(qs1[0]), .CLR(clr_div), .CE(1'b1), .D(ds2), .Q(qs2)
`ifdef DFFCE_PARITY_EN
    , .QP(qps2)
`endif
  );

  dffce_reg #(.WIDTH(8), .IS_C_INVERTED(1'b1), .IS_D_INVERTED(8'h0F)) u8 (
    .C(clk), .CLR(clr8), .CE(ce8), .D(d8), .Q(q8)
`ifdef DFFCE_PARITY_EN
    , .QP(qp8)
`endif
  );

  time t0a = 0, t0b = 0, t1a = 0, t1b = 0, t2a = 0, t2b = 0;
  always @(posedge qs0[0]) begin t0a <= t0b; t0b <= $time; end
  always @(posedge qs1[0]) begin t1a <= t1b; t1b <= $time; end
  always @(posedge qs2[0]) begin t2a <= t2b; t2b <= $time; end

  initial begin
    clr1 = 1'b1; ce1 = 1'b1; d1 = 1'b1;
    clri = 1'b0; cei = 1'b0; di = 8'hFF;
    clr_div = 1'b1;
    clr8 = 1'b1; ce8 = 1'b0; d8 = 8'h00;
    #1;
    check("pwrup_qi", 32'(qi), 32'h38);
`ifdef DFFCE_PARITY_EN
    check("pwrup_qp", 32'(qpi), 32'h1);
`endif
    check("rst_t1", 32'(q1), 32'h0);
    tick(); check("rst_edge1", 32'(q1), 32'h0);
    tick(); check("rst_edge2", 32'(q1), 32'h0);
    clr1 = 1'b0;
    tick(); check("cap_d1", 32'(q1), 32'h1);
    ce1 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("hold_ce0", 32'(q1), 32'h1);
    end
    check("hold_qi_ce0", 32'(qi), 32'h38);
    ce1 = 1'b1;
    tick(); check("cap_d0", 32'(q1), 32'h0);
    d1 = 1'b1;
    tick(); check("cap_d1b", 32'(q1), 32'h1);

    // 2 ns clear pulse midway between rising edges
    #4; clr1 = 1'b1;
    #1; check("aclr_in_pulse", 32'(q1), 32'h0);
    #1; clr1 = 1'b0;
    #1; check("aclr_after_pulse", 32'(q1), 32'h0);
    tick(); check("aclr_reload", 32'(q1), 32'h1);

    // clear held across an enabled edge wins
    #8; clr1 = 1'b1;
    tick(); check("clr_over_edge", 32'(q1), 32'h0);
    tick(); check("clr_held", 32'(q1), 32'h0);
    clr1 = 1'b0;
    tick(); check("clr_release_load", 32'(q1), 32'h1);

    // D wiggle between edges with CE low has no effect
    ce1 = 1'b0; d1 = 1'b0; #2; d1 = 1'b1; #2; d1 = 1'b0;
    tick(); check("d_between_edges", 32'(q1), 32'h1);

    // parity / load on the INIT instance
    cei = 1'b1; di = 8'h07;
    tick(); check("load_07", 32'(qi), 32'h07);
`ifdef DFFCE_PARITY_EN
    check("qp_07", 32'(qpi), 32'h1);
`endif
    di = 8'h03;
    tick(); check("load_03", 32'(qi), 32'h03);
`ifdef DFFCE_PARITY_EN
    check("qp_03", 32'(qpi), 32'h0);
`endif
    di = 8'h07;
    #2; clri = 1'b1;
    #1; check("clr_qi", 32'(qi), 32'h00);
`ifdef DFFCE_PARITY_EN
    check("clr_qp", 32'(qpi), 32'h0);
`endif
    tick(); check("clr_qi_held", 32'(qi), 32'h00);
    clri = 1'b0;

    // ripple divider
    clr_div = 1'b0;
    repeat (30) tick();
    check("div_s0_period", 32'(t0b - t0a), 32'd20);
    check("div_s1_period", 32'(t1b - t1a), 32'd40);
    check("div_s2_period", 32'(t2b - t2a), 32'd80);

    // falling-edge capture with D inversion mask 0F
    @(negedge clk); #1;
    clr8 = 1'b0; d8 = 8'hA5; ce8 = 1'b1;
    check("inv_pre", 32'(q8), 32'h00);
    tick(); check("inv_rise_nochg", 32'(q8), 32'h00);
    @(negedge clk); #1; check("inv_fall_A5", 32'(q8), 32'hAA);
    d8 = 8'h00;
    tick(); check("inv_rise_hold", 32'(q8), 32'hAA);
    @(negedge clk); #1; check("inv_fall_00", 32'(q8), 32'h0F);
    ce8 = 1'b0; d8 = 8'hFF;
    @(negedge clk); #1; check("inv_ce0", 32'(q8), 32'h0F);
    clr8 = 1'b1;
    #1; check("inv_clr", 32'(q8), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 50000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
